// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: tracks EX/MEM writers,
// registers EX operand selects, and drives stall, flush and freeze enables.
module hazard_forward_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic [31:0] hazard_count
);

  // The WB slot is never consulted: its forwarding role is resolved one cycle
  // earlier from the MEM slot, when the selects for the entering EX op are made.
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_rw_q, ex_rw_d;
  logic        ex_mr_q, ex_mr_d;
  logic        mem_valid_q, mem_valid_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_rw_q, mem_rw_d;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [31:0] cnt_q, cnt_d;

  logic freeze, flush, lu_raw, loaduse, insert;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  always_comb begin
    freeze  = mem_access & ~dmem_ready;
    flush   = ex_branch_taken & ~freeze;
    lu_raw  = id_valid & ex_valid_q & ex_mr_q & (ex_rd_q != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
               (id_uses_rs2 & (id_rs2 == ex_rd_q)));
    loaduse = lu_raw & ~freeze & ~flush;
    insert  = ~freeze & ~flush & ~loaduse & id_valid;

    ex_hit_a  = id_uses_rs1 & ex_valid_q & ex_rw_q & (ex_rd_q == id_rs1) & (id_rs1 != 5'd0);
    ex_hit_b  = id_uses_rs2 & ex_valid_q & ex_rw_q & (ex_rd_q == id_rs2) & (id_rs2 != 5'd0);
    mem_hit_a = id_uses_rs1 & mem_valid_q & mem_rw_q & (mem_rd_q == id_rs1) & (id_rs1 != 5'd0);
    mem_hit_b = id_uses_rs2 & mem_valid_q & mem_rw_q & (mem_rd_q == id_rs2) & (id_rs2 != 5'd0);

    // Reset forces the enables to their free-running values.
    pc_write    = reset | ~(freeze | loaduse);
    ifid_write  = reset | ~(freeze | loaduse);
    ifid_flush  = ~reset & flush;
    idex_bubble = ~reset & (flush | loaduse);
    pipe_freeze = ~reset & freeze;
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    mem_valid_d = mem_valid_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    cnt_d       = cnt_q;

    if (!freeze) begin
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_rw_d    = ex_rw_q;
      ex_valid_d  = insert;
      ex_rd_d     = id_rd;
      ex_rw_d     = id_reg_write;
      ex_mr_d     = id_mem_read;
      fwd_a_d     = !insert ? 2'b00 : ex_hit_a ? 2'b10 : mem_hit_a ? 2'b01 : 2'b00;
      fwd_b_d     = !insert ? 2'b00 : ex_hit_b ? 2'b10 : mem_hit_b ? 2'b01 : 2'b00;
    end

    if ((freeze | flush | loaduse) && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_rw_q    <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      cnt_q       <= 32'd0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;
  assign hazard_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken, mem_access, dmem_ready;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
  logic [31:0] hazard_count;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .hazard_count(hazard_count)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  // comb bits are {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  typedef struct {
    string       name;
    logic [4:0]  comb;
    logic [4:0]  cmask;
    logic        chk;
    logic [3:0]  fwd;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   passed = 0;

  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] LDU = 5'b00010;
  localparam logic [4:0] FLU = 5'b10110;
  localparam logic [4:0] FRZ = 5'b00001;
  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] NIW = 5'b10111;

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{v: 1'b1, rs1: rs1, u1: 1'b1, rs2: rs2, u2: 1'b1, rd: rd, rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic instr_t aluImm(input logic [4:0] rd, input logic [4:0] rs1);
    return '{v: 1'b1, rs1: rs1, u1: 1'b1, rs2: 5'd0, u2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rs1);
    return '{v: 1'b1, rs1: rs1, u1: 1'b1, rs2: 5'd0, u2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b1};
  endfunction

  task automatic applyStimulus(input string name, input instr_t ins,
                               input logic rst, input logic br, input logic macc, input logic rdy,
                               input logic [4:0] comb, input logic [4:0] cmask,
                               input logic chk, input logic [3:0] fwd, input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    id_valid        = ins.v;
    id_rs1          = ins.rs1;
    id_uses_rs1     = ins.u1;
    id_rs2          = ins.rs2;
    id_uses_rs2     = ins.u2;
    id_rd           = ins.rd;
    id_reg_write    = ins.rw;
    id_mem_read     = ins.mr;
    ex_branch_taken = br;
    mem_access      = macc;
    dmem_ready      = rdy;
    e.name  = name;
    e.comb  = comb;
    e.cmask = cmask;
    e.chk   = chk;
    e.fwd   = fwd;
    e.cnt   = cnt;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] actComb;
    actComb = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze};
    checks++;
    if ((actComb & e.cmask) === (e.comb & e.cmask)) passed++;
    else $display("[TB] FAIL %s ctrl: got %b want %b (mask %b)", e.name, actComb, e.comb, e.cmask);
    if (e.chk) begin
      checks++;
      if ({fwd_a_sel, fwd_b_sel} === e.fwd) passed++;
      else $display("[TB] FAIL %s fwd: got %b want %b", e.name, {fwd_a_sel, fwd_b_sel}, e.fwd);
      checks++;
      if (hazard_count === e.cnt) passed++;
      else $display("[TB] FAIL %s count: got %0d want %0d", e.name, hazard_count, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;

    applyStimulus("reset0",        nop(),           1, 0, 0, 1, NRM, ALL, 0, 4'b0000, 0);
    applyStimulus("reset1",        nop(),           1, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("add_x5",        alu(5, 1, 2),    0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("sub_x6",        alu(6, 5, 7),    0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("fwd_b2b",       nop(),           0, 0, 0, 1, NRM, ALL, 1, 4'b1000, 0);
    applyStimulus("add_x5b",       alu(5, 1, 2),    0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("gap",           nop(),           0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("or_x8",         alu(8, 1, 5),    0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("fwd_dist2",     alu(5, 1, 2),    0, 0, 0, 1, NRM, ALL, 1, 4'b0001, 0);
    applyStimulus("add_x5c",       alu(5, 3, 4),    0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("or_x8b",        alu(8, 1, 5),    0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("fwd_mem_pri",   aluImm(0, 1),    0, 0, 0, 1, NRM, ALL, 1, 4'b0010, 0);
    applyStimulus("read_x0",       alu(11, 0, 0),   0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("x0_sel",        nop(),           0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("lw_x9",         ld(9, 1),        0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("loaduse",       alu(10, 9, 9),   0, 0, 0, 1, LDU, ALL, 1, 4'b0000, 0);
    applyStimulus("after_stall",   alu(10, 9, 9),   0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 1);
    applyStimulus("lu_fwd",        nop(),           0, 0, 0, 1, NRM, ALL, 1, 4'b0101, 1);
    applyStimulus("lw_x12",        ld(12, 1),       0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 1);
    applyStimulus("flush_lu",      alu(13, 12, 0),  0, 1, 0, 1, FLU, NIW, 1, 4'b0000, 1);
    applyStimulus("ex_empty",      alu(13, 12, 0),  0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 2);
    applyStimulus("lw_x14",        ld(14, 1),       0, 0, 0, 1, NRM, ALL, 1, 4'b0100, 2);
    applyStimulus("add_x15",       alu(15, 13, 2),  0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 2);
    applyStimulus("freeze1",       nop(),           0, 0, 1, 0, FRZ, ALL, 1, 4'b0100, 2);
    applyStimulus("freeze2_br",    alu(16, 5, 5),   0, 1, 1, 0, FRZ, ALL, 1, 4'b0100, 3);
    applyStimulus("freeze3",       nop(),           0, 0, 1, 0, FRZ, ALL, 1, 4'b0100, 4);
    applyStimulus("unfreeze",      alu(16, 15, 14), 0, 0, 1, 1, NRM, ALL, 1, 4'b0100, 5);
    applyStimulus("freeze_held",   nop(),           0, 0, 1, 0, FRZ, ALL, 1, 4'b1001, 5);
    applyStimulus("reset_in_frz",  nop(),           1, 0, 1, 0, NRM, ALL, 1, 4'b1001, 6);
    applyStimulus("reset_vals",    nop(),           1, 0, 1, 0, NRM, ALL, 1, 4'b0000, 0);
    applyStimulus("post_reset",    nop(),           0, 0, 0, 1, NRM, ALL, 1, 4'b0000, 0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage RISC-V core. It tracks the destination registers of in-flight instructions in EX, MEM and WB, and produces the two 2-bit select lines for the EX-stage operand forwarding muxes. It also generates load-use stalls, taken-branch flushes and data-memory wait freezes for the PC and pipeline registers. It sits beside the ID/EX boundary and is the only source of forwarding selects and pipeline-register enables.

## Interface
- No parameters; register index width is fixed at 5 and the counter width at 32.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5  source register indices of the ID instruction.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2.
- id_rd  in  5  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- ex_branch_taken  in  1  instruction in EX resolved a taken branch or jump this cycle.
- mem_access  in  1  MEM-stage instruction is a load or store.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- fwd_a_sel, fwd_b_sel  out  2  registered operand selects for EX: 00 = register file, 01 = WB result, 10 = MEM ALU result; 11 is never driven.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID register enable (combinational).
- ifid_flush  out  1  clear IF/ID to NOP (combinational).
- idex_bubble  out  1  load a NOP into ID/EX (combinational).
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB (combinational).
- hazard_count  out  32  saturating count of cycles with any stall, flush or freeze.

## Operation
- Internal slots EX, MEM and WB each hold {valid, rd, reg_write, mem_read}. The EX slot also holds rs1 and rs2 with their use bits.
- Match rule: a slot matches source r when slot.valid and slot.reg_write and slot.rd == r and r != 0.
- Conditions are evaluated each cycle with the priority freeze > flush > load-use:
  - freeze = mem_access & ~dmem_ready.
  - flush = ex_branch_taken & ~freeze.
  - loaduse = id_valid & EX.valid & EX.mem_read & EX.rd != 0 & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)), gated by ~freeze & ~flush.
- Freeze:
  - pipe_freeze=1, pc_write=0, ifid_write=0.
  - All slots and the fwd selects hold.
- Flush:
  - ifid_flush=1 and idex_bubble=1; pc_write=1 so the branch target loads.
  - Next state: EX slot invalid, MEM←EX, WB←MEM.
- Load-use:
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - Next state: EX invalid, MEM←EX, WB←MEM.
- Normal advance:
  - pc_write=1, ifid_write=1, all other control outputs 0.
  - Next state: EX←ID fields (valid = id_valid), MEM←EX, WB←MEM.
- Forward select update, computed whenever the slots advance:
  - For the incoming EX instruction, per operand: 10 if the incoming MEM slot (current EX) matches and the operand is used; else 01 if the incoming WB slot (current MEM) matches; else 00.
  - MEM has priority over WB.
  - A bubble or an invalid instruction entering EX gives selects 00.
- hazard_count increments by 1 on each cycle where freeze|flush|loaduse and saturates at 0xFFFF_FFFF.

## Timing
- Reset, while reset is high: all slots invalid, fwd selects 00, hazard_count 0. Combinational outputs are forced to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
- Reset mid-stall or mid-freeze takes effect at the next edge regardless of the other inputs.
- The forwarding selects become valid in the first cycle an instruction occupies EX, one edge after it was presented in ID. They stay stable for its whole EX residency, including freeze cycles.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load is in MEM and the dependent instruction, still held in ID, advances with select 01 because the load is then in WB.
- A freeze lasts as long as dmem_ready stays low. There is no timeout.
- ex_branch_taken together with a load-use condition: the flush wins and no stall is counted separately. The cycle counts once.
- ex_branch_taken during a freeze is ignored that cycle. The EX stage is responsible for holding the signal until the freeze clears.

## Test plan
- Back-to-back ALU dependence: add x5 followed by sub x6,x5,x7 -> sub in EX with fwd_a_sel=10, fwd_b_sel=00, no stall.
- Distance-2 dependence: add x5; nop; or x8,x1,x5 -> or in EX with fwd_b_sel=01. With x5 written in both MEM and WB -> 10.
- rd=x0 writer followed by a reader of x0 -> selects 00, no stall.
- Load-use: lw x9; add x10,x9,x9 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1. Then add in EX with both selects 01; hazard_count=1.
- Branch taken while a load-use condition is present in ID -> ifid_flush=1, idex_bubble=1, pc_write=1. The EX slot is empty next cycle; hazard_count increments by 1.
- Load in MEM with dmem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, selects and slots unchanged, hazard_count +3. Assert reset on the 2nd freeze cycle -> all outputs at their reset values after the edge.
